// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes and the
// datapath select codes consumed by the external ALU decoder and muxes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JALR_ADR,
    S_JUMP,
    S_UPPER,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_B = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Unknown opcodes fall back to the I format; their result is never used.
  function automatic logic [2:0] imm_format(input logic [6:0] op);
    case (op)
      OP_STORE:          return IMM_S;
      OP_BRANCH:         return IMM_B;
      OP_JAL:            return IMM_J;
      OP_LUI, OP_AUIPC:  return IMM_U;
      default:           return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller.sv
// Multicycle RV32I main control FSM: sequences fetch, decode, execute,
// memory and write-back, and drives the datapath selects and strobes.
//
// state      | meaning
// FETCH      | read instruction at PC, PC <= PC+4 on completion
// DECODE     | register read, ALUOut <= oldPC+imm, dispatch on op
// MEMADR     | ALUOut <= rs1+imm for load/store
// MEMREAD    | read data memory at ALUOut
// MEMWB      | write loaded data to rd
// MEMWRITE   | store rs2 at ALUOut
// EXEC_R     | ALUOut <= rs1 op rs2
// EXEC_I     | ALUOut <= rs1 op imm
// ALUWB      | write ALUOut to rd
// BRANCH     | compare, PC <= target when taken
// JALR_ADR   | ALUOut <= rs1+imm as jump target
// JUMP       | PC <= ALUOut, ALUOut <= oldPC+4
// UPPER      | ALUOut <= imm (lui) or oldPC+imm (auipc)
// TRAP       | illegal opcode, sticky until reset
import mc_ctrl_pkg::*;

module mc_controller #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit TRAP_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [2:0] immsrc,
  output logic       retire,
  output logic       illegal
);

  state_t state, state_next;
  logic   done;

  assign done   = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign immsrc = imm_format(op);

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pcwrite    = 1'b0;
    adrsrc     = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    resultsrc  = RES_ALUOUT;
    alusrca    = SRCA_PC;
    alusrcb    = SRCB_RS2;
    aluop      = ALUOP_ADD;
    retire     = 1'b0;
    illegal    = 1'b0;

    if (reset) begin
      // Hold the FETCH selects but keep every strobe quiet, whatever the state.
      resultsrc = RES_ALURES;
      alusrcb   = SRCB_FOUR;
    end else begin
      case (state)
        S_FETCH: begin
          resultsrc = RES_ALURES;
          alusrcb   = SRCB_FOUR;
          pcwrite   = done;
          irwrite   = done;
          if (done) state_next = S_DECODE;
        end
        S_DECODE: begin
          alusrca = SRCA_OLDPC;
          alusrcb = SRCB_IMM;
          case (op)
            OP_LOAD, OP_STORE: state_next = S_MEMADR;
            OP_RTYPE:          state_next = S_EXEC_R;
            OP_ITYPE:          state_next = S_EXEC_I;
            OP_BRANCH:         state_next = S_BRANCH;
            OP_JAL:            state_next = S_JUMP;
            OP_JALR:           state_next = S_JALR_ADR;
            OP_LUI, OP_AUIPC:  state_next = S_UPPER;
            default:           state_next = TRAP_EN ? S_TRAP : S_FETCH;
          endcase
        end
        S_MEMADR: begin
          alusrca    = SRCA_RS1;
          alusrcb    = SRCB_IMM;
          state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          adrsrc = 1'b1;
          if (done) state_next = S_MEMWB;
        end
        S_MEMWB: begin
          resultsrc  = RES_RDATA;
          regwrite   = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        S_MEMWRITE: begin
          adrsrc   = 1'b1;
          memwrite = 1'b1;
          retire   = done;
          if (done) state_next = S_FETCH;
        end
        S_EXEC_R: begin
          alusrca    = SRCA_RS1;
          aluop      = ALUOP_FUNCT;
          state_next = S_ALUWB;
        end
        S_EXEC_I: begin
          alusrca    = SRCA_RS1;
          alusrcb    = SRCB_IMM;
          aluop      = ALUOP_FUNCT;
          state_next = S_ALUWB;
        end
        S_ALUWB: begin
          regwrite   = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        S_BRANCH: begin
          alusrca    = SRCA_RS1;
          aluop      = ALUOP_BRANCH;
          pcwrite    = branch_taken;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        S_JALR_ADR: begin
          alusrca    = SRCA_RS1;
          alusrcb    = SRCB_IMM;
          state_next = S_JUMP;
        end
        S_JUMP: begin
          alusrca    = SRCA_OLDPC;
          alusrcb    = SRCB_FOUR;
          pcwrite    = 1'b1;
          state_next = S_ALUWB;
        end
        S_UPPER: begin
          alusrca    = op[5] ? SRCA_ZERO : SRCA_OLDPC;
          alusrcb    = SRCB_IMM;
          state_next = S_ALUWB;
        end
        S_TRAP: begin
          illegal = 1'b1;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: default, TRAP_EN=0 and MEM_WAIT_EN=0
// instances share stimulus; outputs are compared against hand-built vectors.
module tb_mc_controller;

  // Packed view: {pcwrite,adrsrc,memwrite,irwrite,regwrite,resultsrc,alusrca,alusrcb,aluop,retire,illegal}
  localparam logic [14:0] F_GO  = 15'b1_0_0_1_0_10_00_10_00_0_0;
  localparam logic [14:0] F_WT  = 15'b0_0_0_0_0_10_00_10_00_0_0;
  localparam logic [14:0] RST   = 15'b0_0_0_0_0_10_00_10_00_0_0;
  localparam logic [14:0] DEC   = 15'b0_0_0_0_0_00_01_01_00_0_0;
  localparam logic [14:0] EXR   = 15'b0_0_0_0_0_00_10_00_10_0_0;
  localparam logic [14:0] EXI   = 15'b0_0_0_0_0_00_10_01_10_0_0;
  localparam logic [14:0] AWB   = 15'b0_0_0_0_1_00_00_00_00_1_0;
  localparam logic [14:0] MADR  = 15'b0_0_0_0_0_00_10_01_00_0_0;
  localparam logic [14:0] MRD   = 15'b0_1_0_0_0_00_00_00_00_0_0;
  localparam logic [14:0] MWB   = 15'b0_0_0_0_1_01_00_00_00_1_0;
  localparam logic [14:0] MWR_D = 15'b0_1_1_0_0_00_00_00_00_1_0;
  localparam logic [14:0] MWR_W = 15'b0_1_1_0_0_00_00_00_00_0_0;
  localparam logic [14:0] BR_T  = 15'b1_0_0_0_0_00_10_00_01_1_0;
  localparam logic [14:0] BR_N  = 15'b0_0_0_0_0_00_10_00_01_1_0;
  localparam logic [14:0] JMP   = 15'b1_0_0_0_0_00_01_10_00_0_0;
  localparam logic [14:0] LUI   = 15'b0_0_0_0_0_00_11_01_00_0_0;
  localparam logic [14:0] AUI   = 15'b0_0_0_0_0_00_01_01_00_0_0;
  localparam logic [14:0] TRP   = 15'b0_0_0_0_0_00_00_00_00_0_1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0110011;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b1;

  logic [2:0] pcwrite_v, adrsrc_v, memwrite_v, irwrite_v, regwrite_v, retire_v, illegal_v;
  logic [1:0] resultsrc_v [3];
  logic [1:0] alusrca_v [3];
  logic [1:0] alusrcb_v [3];
  logic [1:0] aluop_v [3];
  logic [2:0] immsrc_v [3];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .pcwrite(pcwrite_v[0]), .adrsrc(adrsrc_v[0]), .memwrite(memwrite_v[0]),
    .irwrite(irwrite_v[0]), .regwrite(regwrite_v[0]), .resultsrc(resultsrc_v[0]),
    .alusrca(alusrca_v[0]), .alusrcb(alusrcb_v[0]), .aluop(aluop_v[0]),
    .immsrc(immsrc_v[0]), .retire(retire_v[0]), .illegal(illegal_v[0])
  );

  mc_controller #(.MEM_WAIT_EN(1'b1), .TRAP_EN(1'b0)) dut_nt (
    .clk(clk), .reset(reset), .op(op), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .pcwrite(pcwrite_v[1]), .adrsrc(adrsrc_v[1]), .memwrite(memwrite_v[1]),
    .irwrite(irwrite_v[1]), .regwrite(regwrite_v[1]), .resultsrc(resultsrc_v[1]),
    .alusrca(alusrca_v[1]), .alusrcb(alusrcb_v[1]), .aluop(aluop_v[1]),
    .immsrc(immsrc_v[1]), .retire(retire_v[1]), .illegal(illegal_v[1])
  );

  mc_controller #(.MEM_WAIT_EN(1'b0), .TRAP_EN(1'b1)) dut_nw (
    .clk(clk), .reset(reset), .op(op), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .pcwrite(pcwrite_v[2]), .adrsrc(adrsrc_v[2]), .memwrite(memwrite_v[2]),
    .irwrite(irwrite_v[2]), .regwrite(regwrite_v[2]), .resultsrc(resultsrc_v[2]),
    .alusrca(alusrca_v[2]), .alusrcb(alusrcb_v[2]), .aluop(aluop_v[2]),
    .immsrc(immsrc_v[2]), .retire(retire_v[2]), .illegal(illegal_v[2])
  );

  function automatic logic [14:0] obs(input int i);
    return {pcwrite_v[i], adrsrc_v[i], memwrite_v[i], irwrite_v[i], regwrite_v[i],
            resultsrc_v[i], alusrca_v[i], alusrcb_v[i], aluop_v[i], retire_v[i], illegal_v[i]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive mem_ready for this cycle, compare instance i, advance one clock.
  task automatic step(input string tag, input int i, input logic mr, input logic [14:0] exp);
    mem_ready = mr;
    #1;
    chk(tag, {17'd0, obs(i)}, {17'd0, exp});
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    tick();
    chk("reset_outputs", {17'd0, obs(0)}, {17'd0, RST});
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    do_reset();

    op = 7'b0100011; #1 chk("immsrc_store",  {29'd0, immsrc_v[0]}, 32'd2);
    op = 7'b1100011; #1 chk("immsrc_branch", {29'd0, immsrc_v[0]}, 32'd1);
    op = 7'b1101111; #1 chk("immsrc_jal",    {29'd0, immsrc_v[0]}, 32'd3);
    op = 7'b0110111; #1 chk("immsrc_lui",    {29'd0, immsrc_v[0]}, 32'd4);
    op = 7'b0000011; #1 chk("immsrc_load",   {29'd0, immsrc_v[0]}, 32'd0);

    // R-type, 4 cycles, next fetch follows
    op = 7'b0110011;
    step("r_fetch", 0, 1, F_GO);
    step("r_decode", 0, 1, DEC);
    step("r_exec", 0, 1, EXR);
    step("r_wb", 0, 1, AWB);
    step("r_next_fetch", 0, 1, F_GO);

    // I-type; a stalled fetch first
    do_reset();
    op = 7'b0010011;
    step("i_fetch_wait", 0, 0, F_WT);
    step("i_fetch", 0, 1, F_GO);
    step("i_decode", 0, 0, DEC);
    step("i_exec", 0, 0, EXI);
    step("i_wb", 0, 1, AWB);

    // Load with two wait cycles in MEMREAD; mem_ready low elsewhere is ignored
    do_reset();
    op = 7'b0000011;
    step("ld_fetch", 0, 1, F_GO);
    step("ld_decode", 0, 0, DEC);
    step("ld_memadr", 0, 0, MADR);
    step("ld_memread_w1", 0, 0, MRD);
    step("ld_memread_w2", 0, 0, MRD);
    step("ld_memread_go", 0, 1, MRD);
    step("ld_memwb", 0, 1, MWB);
    step("ld_next_fetch", 0, 1, F_GO);

    // Branch taken / not taken
    do_reset();
    op = 7'b1100011;
    branch_taken = 1'b1;
    step("bt_fetch", 0, 1, F_GO);
    step("bt_decode", 0, 1, DEC);
    step("bt_branch", 0, 1, BR_T);
    branch_taken = 1'b0;
    step("bn_fetch", 0, 1, F_GO);
    step("bn_decode", 0, 1, DEC);
    step("bn_branch", 0, 1, BR_N);
    step("bn_next_fetch", 0, 1, F_GO);

    // jal, jalr, lui, auipc back to back
    op = 7'b1101111;
    step("jal_decode", 0, 1, DEC);
    step("jal_jump", 0, 1, JMP);
    step("jal_wb", 0, 1, AWB);
    op = 7'b1100111;
    step("jalr_fetch", 0, 1, F_GO);
    step("jalr_decode", 0, 1, DEC);
    step("jalr_adr", 0, 1, MADR);
    step("jalr_jump", 0, 1, JMP);
    step("jalr_wb", 0, 1, AWB);
    op = 7'b0110111;
    step("lui_fetch", 0, 1, F_GO);
    step("lui_decode", 0, 1, DEC);
    step("lui_upper", 0, 1, LUI);
    step("lui_wb", 0, 1, AWB);
    op = 7'b0010111;
    step("auipc_fetch", 0, 1, F_GO);
    step("auipc_decode", 0, 1, DEC);
    step("auipc_upper", 0, 1, AUI);
    step("auipc_wb", 0, 1, AWB);

    // Store with one wait cycle
    op = 7'b0100011;
    step("st_fetch", 0, 1, F_GO);
    step("st_decode", 0, 1, DEC);
    step("st_memadr", 0, 1, MADR);
    step("st_memwrite_w", 0, 0, MWR_W);
    step("st_memwrite_go", 0, 1, MWR_D);
    step("st_next_fetch", 0, 1, F_GO);

    // Illegal opcode: sticky trap vs. NOP fallback
    do_reset();
    op = 7'b1111111;
    mem_ready = 1'b1;
    #1;
    chk("ill_fetch", {17'd0, obs(0)}, {17'd0, F_GO});
    chk("ill_nt_fetch", {17'd0, obs(1)}, {17'd0, F_GO});
    tick();
    chk("ill_decode", {17'd0, obs(0)}, {17'd0, DEC});
    chk("ill_nt_decode", {17'd0, obs(1)}, {17'd0, DEC});
    tick();
    chk("ill_nt_back_fetch", {17'd0, obs(1)}, {17'd0, F_GO});
    for (int k = 0; k < 10; k++) begin
      mem_ready = k[0];
      #1;
      chk("ill_trap_hold", {17'd0, obs(0)}, {17'd0, TRP});
      tick();
    end
    do_reset();
    step("trap_exit_fetch", 0, 1, F_GO);

    // Reset in the middle of a stalled store
    do_reset();
    op = 7'b0100011;
    step("rs_fetch", 0, 1, F_GO);
    step("rs_decode", 0, 1, DEC);
    step("rs_memadr", 0, 1, MADR);
    mem_ready = 1'b0;
    #1;
    chk("rs_memwrite_pre", {17'd0, obs(0)}, {17'd0, MWR_W});
    reset = 1'b1;
    #1;
    chk("rs_memwrite_in_reset", {17'd0, obs(0)}, {17'd0, RST});
    tick();
    reset = 1'b0;
    step("rs_fetch_after", 0, 1, F_GO);

    // MEM_WAIT_EN=0: store completes in 4 cycles with mem_ready held low
    do_reset();
    op = 7'b0100011;
    step("nw_fetch", 2, 0, F_GO);
    step("nw_decode", 2, 0, DEC);
    step("nw_memadr", 2, 0, MADR);
    step("nw_memwrite", 2, 0, MWR_D);
    step("nw_next_fetch", 2, 0, F_GO);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
